// File: rtl/fpu_pipe_pkg.sv
// rtl/fpu_pipe_pkg.sv - shared encodings, operand classes and NaN helper for fpu_pipe
package fpu_pipe_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Canonical quiet NaN, returned wide; callers truncate to their word width.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

  // Subnormals (zero exponent, nonzero fraction) are treated as zero.
  function automatic fp_class_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - parametrised leading-zero counter
module fpu_lzc #(
  parameter int W  = 48,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_pipe.sv
// rtl/fpu_pipe.sv - three-stage add/sub/mul floating-point pipeline with tag passthrough
module fpu_pipe
  import fpu_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  input  logic [1:0]         opcode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W+MAN_W:0] O,
  output logic [TAG_W-1:0]   out_tag,
  output logic [3:0]         flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int AW   = MAN_W + 4;
  localparam int SW   = AW + 1;
  localparam int RW   = 2*MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int LW   = $clog2(RW + 1);
  localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX = EW'((2**EXP_W) - 1);

  logic en, out_valid_q;
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;

  // ---------------- S1: unpack, classify, align / multiply ----------------
  logic sa, sb, sb_eff, a_big, s_l, s_s;
  logic [EXP_W-1:0] ea, eb, exa, exb, ex_l, ex_s, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0] ma, mb, m_l, m_s;
  logic [AW-1:0] ms_ext, ms_mask, ms_al;
  fp_class_e ca, cb;
  logic spec1_d, inv1_d;
  logic [W-1:0] sval1_d;
  logic signed [EW-1:0] emul_d;

  assign {sa, ea, fa} = A;
  assign {sb, eb, fb} = B;
  assign sb_eff = sb ^ (opcode == OP_SUB);
  assign ca  = classify(&ea, ~|ea, ~|fa);
  assign cb  = classify(&eb, ~|eb, ~|fb);
  assign exa = (ca == CLS_ZERO) ? '0 : ea;
  assign exb = (cb == CLS_ZERO) ? '0 : eb;
  assign ma  = (ca == CLS_NORMAL) ? {1'b1, fa} : '0;
  assign mb  = (cb == CLS_NORMAL) ? {1'b1, fb} : '0;

  assign a_big = {exa, ma} >= {exb, mb};
  assign ex_l  = a_big ? exa : exb;
  assign ex_s  = a_big ? exb : exa;
  assign m_l   = a_big ? ma : mb;
  assign m_s   = a_big ? mb : ma;
  assign s_l   = a_big ? sa : sb_eff;
  assign s_s   = a_big ? sb_eff : sa;
  assign diff  = ex_l - ex_s;

  // Smaller operand gets guard/round/sticky room; everything shifted out folds into sticky.
  assign ms_ext  = {m_s, 3'b000};
  assign ms_mask = ~({AW{1'b1}} << diff);
  assign ms_al   = (ms_ext >> diff) | {{(AW-1){1'b0}}, |(ms_ext & ms_mask)};
  assign emul_d  = EW'(exa) + EW'(exb) - EW'(BIAS);

  always_comb begin
    spec1_d = 1'b0;
    inv1_d  = 1'b0;
    sval1_d = '0;
    if (opcode == OP_RSV || ca == CLS_NAN || cb == CLS_NAN) begin
      spec1_d = 1'b1; inv1_d = 1'b1; sval1_d = QNAN;
    end else if (opcode == OP_MUL) begin
      if ((ca == CLS_ZERO && cb == CLS_INF) || (ca == CLS_INF && cb == CLS_ZERO)) begin
        spec1_d = 1'b1; inv1_d = 1'b1; sval1_d = QNAN;
      end else if (ca == CLS_INF || cb == CLS_INF) begin
        spec1_d = 1'b1; sval1_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
        spec1_d = 1'b1; sval1_d = {sa ^ sb, {(W-1){1'b0}}};
      end
    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
      if (ca == CLS_INF && cb == CLS_INF && sa != sb_eff) begin
        spec1_d = 1'b1; inv1_d = 1'b1; sval1_d = QNAN;
      end else if (ca == CLS_INF) begin
        spec1_d = 1'b1; sval1_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (cb == CLS_INF) begin
        spec1_d = 1'b1; sval1_d = {sb_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
        spec1_d = 1'b1; sval1_d = {sa & sb_eff, {(W-1){1'b0}}};
      end
    end
  end

  logic v1_q, spec1_q, inv1_q, mul1_q, sub1_q, sgn1_q;
  logic [TAG_W-1:0] tag1_q;
  logic [W-1:0] sval1_q;
  logic signed [EW-1:0] exp1_q;
  logic [AW-1:0] ml1_q, ms1_q;
  logic [RW-1:0] prod1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; spec1_q <= 1'b0; inv1_q <= 1'b0; mul1_q <= 1'b0; sub1_q <= 1'b0;
      sgn1_q <= 1'b0; tag1_q <= '0; sval1_q <= '0; exp1_q <= '0; ml1_q <= '0;
      ms1_q <= '0; prod1_q <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      spec1_q <= spec1_d;
      inv1_q  <= inv1_d;
      mul1_q  <= (opcode == OP_MUL);
      sub1_q  <= s_l ^ s_s;
      sgn1_q  <= (opcode == OP_MUL) ? (sa ^ sb) : s_l;
      tag1_q  <= in_tag;
      sval1_q <= sval1_d;
      exp1_q  <= (opcode == OP_MUL) ? emul_d : EW'(ex_l);
      ml1_q   <= {m_l, 3'b000};
      ms1_q   <= ms_al;
      prod1_q <= RW'(ma) * RW'(mb);
    end
  end

  // ---------------- S2: add/subtract, leading-zero normalise ----------------
  logic [SW-1:0] sum_d;
  logic [RW-1:0] raw_d, norm_d;
  logic [LW-1:0] lz_d;
  logic signed [EW-1:0] exp2_d;

  // Operands are magnitude-ordered in S1, so the difference never goes negative.
  assign sum_d  = sub1_q ? ({1'b0, ml1_q} - {1'b0, ms1_q}) : ({1'b0, ml1_q} + {1'b0, ms1_q});
  assign raw_d  = mul1_q ? prod1_q : {sum_d, {(RW-SW){1'b0}}};

  fpu_lzc #(.W(RW)) u_lzc (.in_i(raw_d), .cnt_o(lz_d));

  assign norm_d = raw_d << lz_d;
  assign exp2_d = exp1_q + EW'(1) - EW'(lz_d);

  logic v2_q, spec2_q, inv2_q, sgn2_q, zero2_q;
  logic [TAG_W-1:0] tag2_q;
  logic [W-1:0] sval2_q;
  logic signed [EW-1:0] exp2_q;
  logic [RW-1:0] norm2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0; spec2_q <= 1'b0; inv2_q <= 1'b0; sgn2_q <= 1'b0; zero2_q <= 1'b0;
      tag2_q <= '0; sval2_q <= '0; exp2_q <= '0; norm2_q <= '0;
    end else if (en) begin
      v2_q    <= v1_q;
      spec2_q <= spec1_q;
      inv2_q  <= inv1_q;
      sgn2_q  <= sgn1_q;
      zero2_q <= ~|raw_d;
      tag2_q  <= tag1_q;
      sval2_q <= sval1_q;
      exp2_q  <= exp2_d;
      norm2_q <= norm_d;
    end
  end

  // ---------------- S3: round to nearest even, pack ----------------
  logic [MAN_W:0] keep;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] frac_r;
  logic g, rest, rup;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0] o_d;
  logic [3:0] flags_d;

  assign keep   = norm2_q[RW-1 -: MAN_W+1];
  assign g      = norm2_q[RW-2-MAN_W];
  assign rest   = |norm2_q[RW-3-MAN_W:0];
  assign rup    = g & (rest | keep[0]);
  assign rnd    = {1'b0, keep} + {{(MAN_W+1){1'b0}}, rup};
  assign exp_r  = exp2_q + EW'(rnd[MAN_W+1]);
  assign frac_r = rnd[MAN_W+1] ? '0 : rnd[MAN_W-1:0];

  always_comb begin
    o_d     = {sgn2_q, exp_r[EXP_W-1:0], frac_r};
    flags_d = '0;
    flags_d[FLG_INEXACT] = g | rest;
    if (spec2_q) begin
      o_d = sval2_q;
      flags_d = '0;
      flags_d[FLG_INVALID] = inv2_q;
    end else if (zero2_q) begin
      o_d = '0;
      flags_d = '0;
    end else if (exp_r <= 0) begin
      o_d = {sgn2_q, {(W-1){1'b0}}};
      flags_d[FLG_UNDERFLOW] = 1'b1;
      flags_d[FLG_INEXACT]   = 1'b1;
    end else if (exp_r >= EMAX) begin
      o_d = {sgn2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d[FLG_OVERFLOW] = 1'b1;
      flags_d[FLG_INEXACT]  = 1'b1;
    end
  end

  logic [W-1:0] o_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [3:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0; o_q <= '0; out_tag_q <= '0; flags_q <= '0;
    end else if (en) begin
      out_valid_q <= v2_q;
      o_q         <= o_d;
      out_tag_q   <= tag2_q;
      flags_q     <= flags_d;
    end
  end

  assign O       = o_q;
  assign out_tag = out_tag_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_fpu_pipe.sv
// tb/tb_fpu_pipe.sv - scoreboard bench for fpu_pipe with directed vectors
module tb_fpu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0, B = '0;
  logic [1:0]  opcode = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] O;
  logic [3:0]  out_tag;
  logic [3:0]  flags;

  fpu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .O(O),
    .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] o;
    logic [3:0]  tag;
    logic [3:0]  fl;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int passed = 0;

  // {A, B, opcode, expected O, expected flags {invalid,overflow,underflow,inexact}}
  logic [31:0] va [16] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h7F800000,
                           32'h00000000, 32'h7F7FFFFF, 32'h3F800000, 32'h40400000,
                           32'h7FC00000, 32'h3F800000, 32'h7F800000, 32'h00800000,
                           32'h80000000, 32'h00000001, 32'h3F800001, 32'h3FC00000};
  logic [31:0] vb [16] = '{32'h40000000, 32'hC0000000, 32'h3F800000, 32'h7F800000,
                           32'h7F800000, 32'h40000000, 32'h33800000, 32'hBF800000,
                           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F000000,
                           32'h80000000, 32'h3F800000, 32'h33800000, 32'h3FC00000};
  logic [1:0]  vop[16] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00,
                           2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
  logic [31:0] vo [16] = '{32'h40400000, 32'hC0C00000, 32'h00000000, 32'h7FC00000,
                           32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h40000000,
                           32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                           32'h80000000, 32'h3F800000, 32'h3F800002, 32'h40100000};
  logic [3:0]  vf [16] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h5, 4'h1, 4'h0,
                           4'h8, 4'h8, 4'h0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  task automatic issue(input int idx, input logic [3:0] tag, input bit push, input bit lat);
    int n;
    n = 0;
    @(negedge clk);
    A = va[idx]; B = vb[idx]; opcode = vop[idx]; in_tag = tag; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL issue_timeout: vector %0d never accepted, expected in_ready", idx);
    end else if (push) begin
      sb_q.push_back('{vo[idx], tag, vf[idx], cyc, lat});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk); #3; n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: pops on every output transfer, checks the held value on every stall.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          if (out_ready) begin
            checks++;
            $display("FAIL unexpected_output: O=%h tag=%0d, expected no output", O, out_tag);
          end
        end else if (out_ready) begin
          e = sb_q.pop_front();
          chk("result_O", O, e.o);
          chk("result_tag", out_tag, e.tag);
          chk("result_flags", flags, e.fl);
          if (e.lat) chk("latency_cycles", cyc - e.acc, 3);
        end else begin
          chk("stall_O", O, sb_q[0].o);
          chk("stall_tag", out_tag, sb_q[0].tag);
          chk("stall_flags", flags, sb_q[0].fl);
        end
      end
    end
  end

  bit toggle_en = 1'b0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    int pi;
    pi = 0;
    forever begin
      @(negedge clk);
      if (toggle_en) begin
        out_ready = pat[pi];
        pi = (pi + 1) % 4;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_O", O, 0);
    chk("reset_flags", flags, 0);
    chk("reset_out_tag", out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_first_edge", in_ready, 1);

    issue(0, 4'd0, 1'b1, 1'b1);
    drain();

    for (int i = 1; i < 16; i++) issue(i, 4'(i), 1'b1, 1'b0);
    drain();

    toggle_en = 1'b1;
    for (int i = 0; i < 8; i++) issue(i, 4'(i), 1'b1, 1'b0);
    drain();
    toggle_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;

    // Three ops in flight, then an asynchronous reset discards them.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(i, 4'(i + 8), 1'b0, 1'b0);
    chk("pre_reset_out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_O", O, 0);
    chk("async_reset_tag", out_tag, 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);
    repeat (6) @(negedge clk);

    issue(14, 4'd5, 1'b1, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fpu_pipe.md
FPU_PIPE -- requirements
Module: fpu_pipe

Interface
REQ-001 Parameter EXP_W, default 8, SHALL set exponent field width.
REQ-002 Parameter MAN_W, default 23, SHALL set stored fraction width (hidden bit excluded); word width W = 1+EXP_W+MAN_W.
REQ-003 Parameter TAG_W, default 4, SHALL set width of the opaque tag carried alongside each operation.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1 -- operation offered; in_ready  output  1 -- block accepts this cycle.
REQ-007 A, B  input  W -- IEEE-754-format operands; opcode  input  2 -- 00 add, 01 sub (A-B), 10 mul, 11 reserved; in_tag  input  TAG_W.
REQ-008 out_valid  output  1; out_ready  input  1; O  output  W -- result; out_tag  output  TAG_W.
REQ-009 flags  output  4 -- {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-010 Transfer SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-011 Pipeline SHALL be 3 stages: S1 unpack/classify/align or mantissa product; S2 add-subtract and leading-zero normalise; S3 round and pack.
REQ-012 Global advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en; all stages hold when en=0.
REQ-013 Latency SHALL be exactly 3 cycles from acceptance to out_valid when no backpressure; throughput 1 op/cycle.
REQ-014 Internal bubbles are not collapsed; each stage SHALL carry its own valid bit.
REQ-015 O, out_tag, flags SHALL remain stable while out_valid && !out_ready.
REQ-016 Rounding SHALL be round-to-nearest-even using guard, round and sticky bits; alignment shift SHALL OR all shifted-out bits into sticky.
REQ-017 Subnormal inputs SHALL be flushed to signed zero; subnormal results SHALL be flushed to signed zero with underflow=1 and inexact=1.
REQ-018 Add/sub exact-zero result SHALL be +0, except (-0)+(-0) = -0.
REQ-019 Any NaN operand, inf-inf (effective subtract), 0*inf, or opcode 11 SHALL yield canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0) with invalid=1.
REQ-020 Inf operand otherwise SHALL yield correctly signed infinity; mul sign = sign(A) xor sign(B).
REQ-021 Rounded exponent >= all-ones SHALL yield signed infinity with overflow=1, inexact=1.
REQ-022 Mantissa carry-out from rounding SHALL increment the exponent and re-check overflow.
REQ-023 Mul exponent SHALL be computed in EXP_W+2 bits signed with bias 2^(EXP_W-1)-1 to detect over/underflow without wrap.
REQ-024 out_tag SHALL equal the in_tag accepted with that operation; results SHALL leave in acceptance order.

Reset
REQ-025 On rst_n=0 all stage valid bits, out_valid, O, out_tag and flags SHALL clear to 0 immediately; in-flight operations are discarded.
REQ-026 After rst_n deasserts, in_ready SHALL be 1 on the first clock edge.

Structure
REQ-027 Shared package SHALL hold opcode encodings, flag bit indices, operand-class enum (zero, normal, inf, nan) and qNaN constant function of EXP_W/MAN_W.
REQ-028 A single sub-module fpu_lzc (parametrised leading-zero counter) SHALL be used by S2; no other sub-modules.

Verification
REQ-029 Add 0x3F800000 + 0x40000000 -> O=0x40400000, flags=0000, out_valid exactly 3 cycles after accept.
REQ-030 Mul 0x40400000 * 0xC0000000 -> 0xC0C00000; sub 0x3F800000 - 0x3F800000 -> 0x00000000, flags=0000.
REQ-031 Sub 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1; mul 0x00000000 * 0x7F800000 -> 0x7FC00000, invalid=1.
REQ-032 Mul 0x7F7FFFFF * 0x40000000 -> 0x7F800000, overflow=1, inexact=1; add 0x3F800000 + 0x33800000 -> 0x3F800000, inexact=1 (tie to even).
REQ-033 Stream 8 ops with tags 0..7, out_ready toggling 1-0-0-1 -> all 8 results in order, no loss/duplication, O stable while stalled.
REQ-034 Assert rst_n low with 3 ops in flight -> out_valid=0 same cycle, none of the 3 emitted after release; next op completes normally.
